// File: rtl/cp0_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_reg_if
//  Description : Bus bundle between the pipeline and the CP0 register file:
//                MTC0/MFC0 ports, exception inputs and the register views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    // Pipeline side: drives requests, observes register contents
    modport master (
        output we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
               current_inst_addr_i, is_in_delayslot_i,
        input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
               config_o, prid_o, timer_int_o
    );

    // Register-file side
    modport slave (
        input  we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
               current_inst_addr_i, is_in_delayslot_i,
        output data_o, count_o, compare_o, status_o, cause_o, epc_o,
               config_o, prid_o, timer_int_o
    );
endinterface
`default_nettype wire

// File: rtl/cp0_reg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_reg
//  Description : Coprocessor-0 register file (Count, Compare, Status, Cause,
//                EPC, PRId, Config) with Count/Compare timer and exception
//                state capture from the memory stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_RESET = 32'h00008000,
    parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    cp0_reg_if.slave   bus
);

    localparam logic [4:0]  c_ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  c_ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  c_ADDR_STATUS  = 5'd12;
    localparam logic [4:0]  c_ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  c_ADDR_EPC     = 5'd14;
    localparam logic [4:0]  c_ADDR_PRID    = 5'd15;
    localparam logic [4:0]  c_ADDR_CONFIG  = 5'd16;

    localparam logic [31:0] c_EXC_INT  = 32'h00000001;
    localparam logic [31:0] c_EXC_SYS  = 32'h00000008;
    localparam logic [31:0] c_EXC_RI   = 32'h0000000A;
    localparam logic [31:0] c_EXC_OV   = 32'h0000000C;
    localparam logic [31:0] c_EXC_TR   = 32'h0000000D;
    localparam logic [31:0] c_EXC_ERET = 32'h0000000E;

    // Software-writable Cause bits: IV, WP, IP1:0
    localparam logic [31:0] c_CAUSE_WMASK = 32'h00C00300;

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_config;
    logic [31:0] r_prid;
    logic        r_timer_int;

    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_match;
    logic [31:0] w_cause_merge;
    logic [31:0] w_exc_pc;
    logic [31:0] w_status_next;
    logic [31:0] w_cause_next;
    logic [31:0] w_epc_next;
    logic [31:0] w_rdata;

    assign w_wr_count    = bus.we_i && (bus.waddr_i == c_ADDR_COUNT);
    assign w_wr_compare  = bus.we_i && (bus.waddr_i == c_ADDR_COMPARE);
    assign w_wr_status   = bus.we_i && (bus.waddr_i == c_ADDR_STATUS);
    assign w_wr_cause    = bus.we_i && (bus.waddr_i == c_ADDR_CAUSE);
    assign w_wr_epc      = bus.we_i && (bus.waddr_i == c_ADDR_EPC);
    assign w_match       = (r_compare != 32'd0) && (r_count == r_compare);
    assign w_cause_merge = (r_cause & ~c_CAUSE_WMASK) | (bus.data_i & c_CAUSE_WMASK);
    assign w_exc_pc      = bus.is_in_delayslot_i ? (bus.current_inst_addr_i - 32'd4)
                                                 : bus.current_inst_addr_i;

    // Next Status/Cause/EPC: MTC0 first, then exception fields override it
    always_comb begin
        w_status_next        = w_wr_status ? bus.data_i : r_status;
        w_epc_next           = w_wr_epc    ? bus.data_i : r_epc;
        w_cause_next         = w_wr_cause  ? w_cause_merge : r_cause;
        w_cause_next[15:10]  = bus.int_i;
        case (bus.excepttype_i)
            c_EXC_INT: begin
                w_epc_next         = w_exc_pc;
                w_cause_next[31]   = bus.is_in_delayslot_i;
                w_status_next[1]   = 1'b1;
                w_cause_next[6:2]  = 5'd0;
            end
            c_EXC_SYS, c_EXC_RI, c_EXC_OV, c_EXC_TR: begin
                // Nested exception while EXL is set keeps the original EPC/BD
                if (!r_status[1]) begin
                    w_epc_next       = w_exc_pc;
                    w_cause_next[31] = bus.is_in_delayslot_i;
                end
                w_status_next[1]  = 1'b1;
                w_cause_next[6:2] = bus.excepttype_i[6:2] == 5'd0 ? bus.excepttype_i[4:0]
                                                                 : bus.excepttype_i[4:0];
            end
            c_EXC_ERET: begin
                w_status_next[1] = 1'b0;
            end
            default: ;
        endcase
    end

    // Register state update, reset overriding everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_status    <= STATUS_RESET;
            r_cause     <= 32'd0;
            r_epc       <= 32'd0;
            r_config    <= CONFIG_RESET;
            r_prid      <= PRID_VALUE;
            r_timer_int <= 1'b0;
        end else begin
            r_count  <= w_wr_count ? bus.data_i : (r_count + 32'd1);
            r_status <= w_status_next;
            r_cause  <= w_cause_next;
            r_epc    <= w_epc_next;
            r_config <= r_config;
            r_prid   <= r_prid;
            // Compare write clears the timer even if a match happens this cycle
            if (w_wr_compare) begin
                r_compare   <= bus.data_i;
                r_timer_int <= 1'b0;
            end else if (w_match) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    // MFC0 read with forwarding of a same-cycle MTC0 to the same register
    always_comb begin
        case (bus.raddr_i)
            c_ADDR_COUNT:   w_rdata = r_count;
            c_ADDR_COMPARE: w_rdata = r_compare;
            c_ADDR_STATUS:  w_rdata = r_status;
            c_ADDR_CAUSE:   w_rdata = r_cause;
            c_ADDR_EPC:     w_rdata = r_epc;
            c_ADDR_PRID:    w_rdata = r_prid;
            c_ADDR_CONFIG:  w_rdata = r_config;
            default:        w_rdata = 32'd0;
        endcase
        if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
            case (bus.waddr_i)
                c_ADDR_COUNT, c_ADDR_COMPARE,
                c_ADDR_STATUS, c_ADDR_EPC: w_rdata = bus.data_i;
                c_ADDR_CAUSE:              w_rdata = w_cause_merge;
                default: ;
            endcase
        end
    end

    assign bus.data_o      = w_rdata;
    assign bus.count_o     = r_count;
    assign bus.compare_o   = r_compare;
    assign bus.status_o    = r_status;
    assign bus.cause_o     = r_cause;
    assign bus.epc_o       = r_epc;
    assign bus.config_o    = r_config;
    assign bus.prid_o      = r_prid;
    assign bus.timer_int_o = r_timer_int;

endmodule
`default_nettype wire

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file for the five-stage MIPS core. It holds Count, Compare, Status, Cause, EPC, PRId and Config, and runs the Count/Compare timer. It records exception state (EPC, Cause.BD, Cause.ExcCode, Status.EXL) from the memory-stage exception type, which is the same value presented to the pipeline controller. It produces `epc_o`, the ERET target consumed by the controller's `cp0_epc_i`, and the Status/Cause views the memory stage uses to detect interrupts.

## Interface
Parameters:
- PRID_VALUE, 32'h004C0102, read-only PRId contents
- CONFIG_RESET, 32'h00008000, Config reset value (BE=1, big-endian)
- STATUS_RESET, 32'h10000000, Status reset value (CU0=1, EXL=0, IE=0)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- we_i  in  1  MTC0 write enable (from writeback)
- waddr_i  in  5  write register number
- raddr_i  in  5  MFC0 read register number
- data_i  in  32  write data
- int_i  in  6  hardware interrupt lines; int_i[5] is externally tied to timer_int_o
- excepttype_i  in  32  exception code from the memory stage
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  the excepting instruction is in a delay slot
- data_o  out  32  combinational read data
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  registered contents
- timer_int_o  out  1  timer interrupt, sticky

## Operation
- Register map: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config. Writes to any other address, including 15 and 16, are ignored.
- Reset values when rst=0 at an edge: count 0, compare 0, status STATUS_RESET, cause 0, epc 0, config CONFIG_RESET, prid PRID_VALUE, timer_int_o 0. Reset overrides every other input.
- Count:
  - Increments by 1 every cycle, modulo 2^32 (0xFFFFFFFF wraps to 0).
  - An MTC0 to Count loads data_i and suppresses that cycle's increment.
- Timer:
  - Sets timer_int_o=1 at the edge where compare≠0 and count==compare (pre-increment values).
  - timer_int_o stays 1 until an MTC0 to Compare, which loads Compare and clears timer_int_o.
  - If a clear and a match occur in the same cycle, the clear wins.
- Cause:
  - cause[15:10] samples int_i every cycle.
  - MTC0 writes only cause[9:8] (IP1:0), cause[22] (WP) and cause[23] (IV). All other bits are read-only to software.
- Status and EPC: MTC0 writes all 32 bits.
- Exception update, applied at the same edge and overriding an MTC0 write on any overlapping field:
  - Interrupt, 0x00000001 (ExcCode 0):
    - epc ← current_inst_addr_i − 4 if is_in_delayslot_i, else current_inst_addr_i
    - cause[31] ← is_in_delayslot_i
    - status[1] ← 1
    - cause[6:2] ← 0
  - 0x08 syscall (code 8), 0x0A reserved instruction (10), 0x0C overflow (12), 0x0D trap (13):
    - EPC and BD are updated as for an interrupt only when status[1]==0; otherwise both are left unchanged.
    - status[1] ← 1 and cause[6:2] ← code in both cases.
  - ERET, 0x0000000E: status[1] ← 0 only.
  - 0 or any other value: no exception update.
- Read port:
  - data_o selects by raddr_i; unmapped addresses return 0.
  - When we_i=1 and waddr_i==raddr_i, data_o returns the value that will be written (for Cause, the masked merge) instead of the stored value.

## Timing
- Every register update becomes visible on the *_o outputs one cycle after the edge that writes it.
- data_o is combinational, with zero-latency forwarding from the write port.
- epc_o is registered, so the controller sees the new EPC the cycle after the exception edge. A back-to-back ERET therefore reads the post-exception EPC.
- The count==compare match registers timer_int_o at that edge, so timer_int_o rises one cycle after the match condition.
- Reset mid-operation discards any pending MTC0 write or exception on the same edge.

## Test plan
- Release reset and run 5 cycles -> count_o=5, status_o=32'h10000000, config_o=32'h00008000, prid_o=32'h004C0102, timer_int_o=0.
- MTC0 Compare=10 with Count=0 -> timer_int_o rises when count_o reaches 11 and stays high; MTC0 Compare=100 -> timer_int_o=0 next cycle.
- excepttype 0x0C, PC 0x80000104, delay slot=1, EXL=0 -> epc_o=0x80000100, cause_o[31]=1, cause_o[6:2]=12, status_o[1]=1; then a syscall with EXL=1 -> EPC unchanged, ExcCode=8.
- MTC0 Cause=0xFFFFFFFF with int_i=6'b000001 -> cause_o=0x00C00700 (bits 23:22, 9:8 and IP2 from int_i); data_o for raddr 13 shows the merged value in the write cycle.
- ERET (0x0E) after an exception -> status_o[1]=0 and epc_o unchanged; MTC0 EPC on the same edge as an exception -> the exception value is stored.
- Count at 0xFFFFFFFF -> wraps to 0; rst=0 asserted together with MTC0 Count -> count_o=0.
